md_sched: RTL
=============

MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- Start_E  in  1  E-stage instruction is a valid HI/LO operation this cycle
- Op_E  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 11x reserved
- A_E  in  32  rs operand (forwarded)
- B_E  in  32  rt operand (forwarded)
- Kill_E  in  1  exception/interrupt flush of the E-stage instruction this cycle
- Use_MD_D  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- Busy  out  1  multi-cycle operation in flight
- Stall_MD  out  1  stall request to the hazard unit (same semantics as Stall_D)
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register
REQ-002 Only clk and reset SHALL be clocking/reset inputs; reset is synchronous, active-high (decided).

Function
REQ-003 Accept = Start_E & ~Kill_E & ~Busy; a Start_E while Busy or with Kill_E SHALL be ignored with no state change.
REQ-004 FSM states SHALL be IDLE, MULT, DIV; Busy = (state != IDLE).
REQ-005 IDLE->MULT on Accept with Op_E 000/001; counter loaded with 5.
REQ-006 IDLE->DIV on Accept with Op_E 010/011; counter loaded with 10.
REQ-007 In MULT/DIV the counter SHALL decrement by 1 per cycle; at counter==1 the next edge SHALL return to IDLE and write HI/LO.
REQ-008 Busy SHALL be high exactly 5 cycles (mult) or 10 cycles (div), starting the cycle after Accept.
REQ-009 Operands SHALL be captured at Accept; later A_E/B_E changes SHALL not affect the result.
REQ-010 mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-011 div: LO = quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-012 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-013 Divisor 0: Busy SHALL still run 10 cycles; HI and LO SHALL remain unchanged.
REQ-014 mthi/mtlo on Accept SHALL write A_E into HI/LO at the next edge, never assert Busy, leave the other register unchanged.
REQ-015 Reserved Op_E on Accept SHALL cause no state change.
REQ-016 HI/LO SHALL hold their old values throughout MULT/DIV until the completion edge.
REQ-017 Kill_E while Busy SHALL NOT cancel the in-flight operation.
REQ-018 Stall_MD = Use_MD_D & (Busy | (Start_E & ~Kill_E)), combinational.
REQ-019 Stall_MD SHALL deassert in the cycle after the completion edge, so a following mfhi/mflo reads the new HI/LO.

Reset
REQ-020 While reset is high at a clock edge: state=IDLE, counter=0, HI=0, LO=0, captured operands=0.
REQ-021 Reset mid-operation SHALL abort it: Busy=0 next cycle, HI/LO=0, no late write.
REQ-022 Busy and Stall_MD SHALL be 0 in the cycle after reset (inputs idle).

Verification
REQ-023 mult A=0xFFFFFFFE, B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-024 div A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> 10 busy cycles, HI/LO unchanged.
REQ-025 mult issued, Use_MD_D=1 (mflo in D) -> Stall_MD high in the Start cycle plus 5 busy cycles, low after; second Start_E during Busy ignored.
REQ-026 Start_E=1, Kill_E=1, Op=mult -> Busy stays 0, HI/LO unchanged; Kill_E asserted mid-div -> div completes normally.
REQ-027 mthi A=0x12345678 -> HI=0x12345678 next cycle, LO unchanged, Busy never high; reset asserted at cycle 3 of a div -> Busy=0, HI=LO=0, no write at cycle 10.

Source files
------------

// File: rtl/md_sched.sv
// HI/LO multiply-divide scheduler for the E stage.
// Fixed-latency mult (5) and div (10) with hazard-unit stall output.
module md_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start_E,
  input  logic [2:0]  Op_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic        Kill_E,
  input  logic        Use_MD_D,
  output logic        Busy,
  output logic        Stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sgn_q;
  logic        accept;

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [32:0] dvd;
  logic signed [32:0] dvs;
  logic signed [32:0] quo;
  logic signed [32:0] rem;
  logic               unused_div_msbs;

  assign Busy     = (state != IDLE);
  assign accept   = Start_E & ~Kill_E & ~Busy;
  assign Stall_MD = Use_MD_D & (Busy | (Start_E & ~Kill_E));

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) *
                  $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // 33-bit signed divide keeps 0x80000000 / -1 representable.
  assign dvd = sgn_q ? {a_q[31], a_q} : {1'b0, a_q};
  assign dvs = (b_q == 32'd0) ? 33'sd1 :
               (sgn_q ? {b_q[31], b_q} : {1'b0, b_q});
  assign quo = dvd / dvs;
  assign rem = dvd % dvs;
  assign unused_div_msbs = quo[32] ^ rem[32];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      sgn_q <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (Op_E)
              OP_MULT, OP_MULTU: begin
                state <= MULT;
                cnt   <= 4'd5;
                a_q   <= A_E;
                b_q   <= B_E;
                sgn_q <= ~Op_E[0];
              end
              OP_DIV, OP_DIVU: begin
                state <= DIV;
                cnt   <= 4'd10;
                a_q   <= A_E;
                b_q   <= B_E;
                sgn_q <= ~Op_E[0];
              end
              OP_MTHI: HI <= A_E;
              OP_MTLO: LO <= A_E;
              default: ;
            endcase
          end
        end
        MULT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            if (sgn_q) begin
              HI <= prod_s[63:32];
              LO <= prod_s[31:0];
            end else begin
              HI <= prod_u[63:32];
              LO <= prod_u[31:0];
            end
          end
        end
        DIV: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            // A zero divisor still burns the full latency but writes nothing.
            if (b_q != 32'd0) begin
              HI <= rem[31:0];
              LO <= quo[31:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule
